// File: rtl/ppu_pkg.sv
// ---------------------------------------------------------------------------
// ppu_pkg
// Shared widths and types for the posit processing unit datapath.
//   N                    : posit width
//   MANT_ADD_RESULT_SIZE : width of the mantissa adder/subtractor result
//                          (MSB = carry position, MSB-1 = hidden bit H)
//   TE_SIZE              : width of the two's-complement total exponent
//   HIDDEN_POS           : index of the hidden bit H in the adder result
//   core_sub_norm_state_t: FSM states of the post-subtraction normalizer
// ---------------------------------------------------------------------------
package ppu_pkg;

    localparam int N                    = 16;
    localparam int MANT_SIZE            = N - 2;
    localparam int MANT_ADD_RESULT_SIZE = 2 * MANT_SIZE;
    localparam int TE_SIZE              = $clog2(N) + 3;
    localparam int HIDDEN_POS           = MANT_ADD_RESULT_SIZE - 2;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } core_sub_norm_state_t;

endpackage

// File: rtl/core_sub_norm_step.sv
// ---------------------------------------------------------------------------
// core_sub_norm_step
// One left-normalization step of the post-subtraction normalizer (pure
// combinational). Shifts the working mantissa left by s and lowers the
// exponent by the same amount.
//   mant      in  : working mantissa (carry bit is known to be 0)
//   te        in  : working total-exponent difference
//   mant_next out : mant << s
//   te_next   out : te - s (TE_SIZE-bit wrap)
//   hit       out : hidden bit of mant_next is set, normalization finished
// Build option: CORE_SUB_NORM_FAST_SHIFT_EN
//   defined   -> s = 4 when bits [H:H-3] are all 0, otherwise s = 1
//   undefined -> s = 1 every step
// ---------------------------------------------------------------------------
module core_sub_norm_step
    import ppu_pkg::*;
(
    input  logic [MANT_ADD_RESULT_SIZE-1:0] mant,
    input  logic [TE_SIZE-1:0]              te,
    output logic [MANT_ADD_RESULT_SIZE-1:0] mant_next,
    output logic [TE_SIZE-1:0]              te_next,
    output logic                            hit
);

    logic shift_by_four;

    // A 4-bit jump is only taken when the top four candidate positions are
    // all zero, so the hidden bit can never be overshot.
    always_comb begin
        shift_by_four = 1'b0;
`ifdef CORE_SUB_NORM_FAST_SHIFT_EN
        shift_by_four = (mant[HIDDEN_POS -: 4] == 4'b0000);
`endif
        if (shift_by_four) begin
            mant_next = mant << 4;
            te_next   = te - TE_SIZE'(4);
        end else begin
            mant_next = mant << 1;
            te_next   = te - TE_SIZE'(1);
        end
        hit = mant_next[HIDDEN_POS];
    end

endmodule

// File: rtl/core_sub_norm.sv
// ---------------------------------------------------------------------------
// core_sub_norm
// Multi-cycle post-subtraction normalizer between the mantissa
// adder/subtractor and the posit encoder. Handles the carry-out case with a
// single right shift, the all-zero case, and left-normalizes everything else
// until the hidden bit H is set.
//   clk, rst_n     : clock (rising edge), asynchronous active-low reset
//   in_valid/ready : input handshake (accept only in IDLE)
//   mant_i         : raw mantissa difference, MSB = carry, MSB-1 = H
//   te_diff_i      : two's-complement total-exponent difference
//   sticky_i       : sticky bit from alignment
//   out_valid/ready: output handshake (results held while out_ready = 0)
//   new_mant       : normalized mantissa (bit H = 1 unless zero)
//   new_te_diff    : adjusted exponent difference
//   frac_truncated : 1 shifted out by the carry right shift, ORed with sticky
//   zero           : input mantissa was all zeros
// Build option: CORE_SUB_NORM_FAST_SHIFT_EN (see core_sub_norm_step); it only
// changes latency, never the result.
// ---------------------------------------------------------------------------
module core_sub_norm
    import ppu_pkg::*;
(
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic                            in_valid,
    output logic                            in_ready,
    input  logic [MANT_ADD_RESULT_SIZE-1:0] mant_i,
    input  logic [TE_SIZE-1:0]              te_diff_i,
    input  logic                            sticky_i,
    output logic                            out_valid,
    input  logic                            out_ready,
    output logic [MANT_ADD_RESULT_SIZE-1:0] new_mant,
    output logic [TE_SIZE-1:0]              new_te_diff,
    output logic                            frac_truncated,
    output logic                            zero
);

    core_sub_norm_state_t state;

    logic [MANT_ADD_RESULT_SIZE-1:0] step_mant;
    logic [TE_SIZE-1:0]              step_te;
    logic                            step_hit;

    // The output registers double as the working registers during SHIFT;
    // they are only presented as valid once the FSM reaches DONE.
    core_sub_norm_step u_step (
        .mant      (new_mant),
        .te        (new_te_diff),
        .mant_next (step_mant),
        .te_next   (step_te),
        .hit       (step_hit)
    );

    // Single FSM block; all handshake and result outputs are registered.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= IDLE;
            in_ready       <= 1'b1;
            out_valid      <= 1'b0;
            new_mant       <= '0;
            new_te_diff    <= '0;
            frac_truncated <= 1'b0;
            zero           <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid && in_ready) begin
                        in_ready       <= 1'b0;
                        new_mant       <= mant_i;
                        new_te_diff    <= te_diff_i;
                        frac_truncated <= sticky_i;
                        zero           <= 1'b0;
                        if (mant_i[MANT_ADD_RESULT_SIZE-1]) begin
                            // Carry out: one right shift, the lost LSB joins sticky.
                            new_mant       <= mant_i >> 1;
                            new_te_diff    <= te_diff_i + TE_SIZE'(1);
                            frac_truncated <= mant_i[0] | sticky_i;
                            state          <= DONE;
                            out_valid      <= 1'b1;
                        end else if (mant_i == '0) begin
                            zero      <= 1'b1;
                            state     <= DONE;
                            out_valid <= 1'b1;
                        end else if (mant_i[HIDDEN_POS]) begin
                            state     <= DONE;
                            out_valid <= 1'b1;
                        end else begin
                            state <= SHIFT;
                        end
                    end
                end
                SHIFT: begin
                    new_mant    <= step_mant;
                    new_te_diff <= step_te;
                    if (step_hit) begin
                        state     <= DONE;
                        out_valid <= 1'b1;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state     <= IDLE;
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                    end
                end
                default: begin
                    state     <= IDLE;
                    out_valid <= 1'b0;
                    in_ready  <= 1'b1;
                end
            endcase
        end
    end

endmodule
